if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch address stage. Owns the PC and drives vaddr into the instruction MMU.
//  Consumes the MMU's psyaddr/uncached/TLB-exception outputs and issues requests to the icache.
//  Tracks in-order outstanding requests and delivers {pc, inst, exc} to decode over valid/ready.
// PARAMETERS
//  RESET_PC    32'hBFC0_0000  PC loaded on reset
//  DEPTH       4              max fetch entries (queued + in-flight + cancelled); power of 2, >=2
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  resetn           in   1   synchronous active-low reset
//  redirect         in   1   squash everything and refetch from redirect_pc (exception/ERET/branch)
//  redirect_pc      in   32  new PC
//  mmu_en           out  1   translation request valid
//  mmu_vaddr        out  32  = pc
//  mmu_psyaddr_ena  in   1   translation hit and valid (direct-mapped or TLB)
//  mmu_psyaddr      in   32  physical address
//  mmu_uncached     in   1   uncached attribute
//  mmu_tlb_refill   in   1   TLB refill exception (TLBL)
//  mmu_tlb_invalid  in   1   TLB invalid exception (TLBL)
//  inst_req         out  1   icache request
//  inst_uncached    out  1   = mmu_uncached
//  inst_addr        out  32  = mmu_psyaddr
//  inst_addr_ok     in   1   request accepted this cycle
//  inst_data_ok     in   1   oldest accepted request returns data
//  inst_rdata       in   32  instruction word
//  out_valid        out  1   head entry complete
//  out_ready        in   1   decode accepts the head entry
//  out_pc           out  32  PC of the head entry
//  out_inst         out  32  instruction; 32'h0 for exception entries
//  out_exc          out  3   {adel, tlb_invalid, tlb_refill}; at most one bit set
// BEHAVIOUR
//  - Reset: pc=RESET_PC; FIFO empty; cancel_cnt=0; exc_hold=0; out_valid=0; inst_req=0.
//  - mmu_en = ~exc_hold & (cnt+cancel_cnt < DEPTH) & ~redirect; mmu_vaddr = pc.
//  - inst_req = mmu_en & mmu_psyaddr_ena. Held stable with pc until inst_addr_ok.
//  - On req & addr_ok: allocate tail entry {pc, done=0}; pc <= pc+4 (mod 2^32 wrap).
//  - mmu_en & ~mmu_psyaddr_ena with refill|invalid: allocate an entry with done=1, exc set, inst=0.
//    No cache request is made. exc_hold<=1 and pc is frozen until redirect.
//  - data_ok with cancel_cnt>0: drop the data and decrement cancel_cnt.
//  - data_ok with cancel_cnt==0: write inst into the oldest entry with done=0 and set done=1.
//  - out_valid = head.done. On out_valid & out_ready, pop the head. Zero-bubble back-to-back pops.
//  - Push, fill and pop may all occur in one cycle.
//  - redirect (priority over all else):
//    - FIFO cleared; exc_hold<=0; pc<=redirect_pc.
//    - cancel_cnt <= cancel_cnt + (#entries done=0) + (req&addr_ok this cycle) - (data_ok this cycle).
//    - out_valid forced 0 in the cycle after.
//  - data_ok never arrives without an outstanding request; an unexpected data_ok is ignored.
//  - Full: no mmu_en/inst_req while cnt+cancel_cnt==DEPTH. Empty: out_valid=0.
//  - Latency: redirect -> inst_req next cycle; data_ok -> out_valid next cycle (registered).
// CONFIGURATION
//  IF_ADEL_CHECK_EN defined:
//    - pc[1:0]!=0 allocates an exception entry with out_exc=3'b100 and no MMU/cache request.
//    - mmu_en=0 for that PC; exc_hold<=1.
//  IF_ADEL_CHECK_EN undefined:
//    - No alignment check; inst_addr low bits passed through unchanged; out_exc[2] is always 0.
// STRUCTURE
//  - if_defs.vh:
//    - EXC_REFILL/EXC_INVALID/EXC_ADEL bit positions; entry field widths.
//    - NOP 32'h0.
//  - Sub-module if_inst_fifo:
//    - DEPTH-entry circular buffer of {pc, inst, exc, done} with head/tail/fill pointers.
//    - Pointers wrap mod DEPTH; synchronous clear.
//  - Top level holds pc, exc_hold, cancel_cnt and the handshake glue.
// TESTING
//  1. Reset release, addr_ok every cycle, data_ok 1 cycle later, out_ready=1 -> pcs BFC00000, ..04, ..08 out in order; no bubbles after first.
//  2. out_ready=0, addr_ok=1 -> exactly 4 requests accepted; inst_req stays 0 while full; one pop -> exactly one new request.
//  3. 3 requests outstanding, redirect to 80001000 -> next 3 data_ok dropped; first delivered out_pc=80001000 with the 4th data_ok's word.
//  4. mmu_psyaddr_ena=0 with mmu_tlb_refill=1 at pc 00400000 -> out_exc=001, out_inst=0; no inst_req until redirect.
//  5. redirect same cycle as addr_ok and data_ok -> cancel_cnt accounting correct; no stale word delivered (scoreboard).
//  6. (IF_ADEL_CHECK_EN) redirect_pc=80000002 -> out_exc=100, mmu_en=0, inst_req never asserted.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: exception bit positions, the fetch entry record, the NOP word and the
//          exception-vector builder used when an entry is allocated without a cache access.
package if_fetch_stage_pkg;

  localparam int EXC_REFILL  = 0;
  localparam int EXC_INVALID = 1;
  localparam int EXC_ADEL    = 2;
  localparam int EXC_W       = 3;

  localparam logic [31:0] NOP = 32'h0;

  // One fetch slot: pc of the fetch, returned word, exception vector, and
  // whether the slot is complete (data arrived or exception recorded).
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [EXC_W-1:0] exc;
    logic             done;
  } fetch_entry_t;

  // Builds a one-hot exception vector; if the MMU flags both TLB errors
  // the refill is reported, since it is the one the handler must fix first.
  function automatic logic [EXC_W-1:0] make_exc(input logic adel, input logic invalid,
                                                input logic refill);
    logic [EXC_W-1:0] e;
    e = '0;
    if (adel) begin
      e[EXC_ADEL] = 1'b1;
    end else if (refill) begin
      e[EXC_REFILL] = 1'b1;
    end else if (invalid) begin
      e[EXC_INVALID] = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-cache request/response bus
// Purpose: groups the icache handshake between the fetch stage (master) and the icache (slave).
// Signals: inst_req/inst_uncached/inst_addr (request), inst_addr_ok (accept),
//          inst_data_ok/inst_rdata (in-order response).
interface if_fetch_stage_if;
  logic        inst_req;
  logic        inst_uncached;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_uncached, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_uncached, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_fetch_stage_inst_fifo.sv
// rtl/if_fetch_stage_inst_fifo.sv - in-order buffer of fetch entries
// Purpose: DEPTH-entry circular buffer of {pc, inst, exc, done} with head/tail pointers,
//          a fill target (oldest entry still waiting for data) and synchronous clear.
// Ports: clk, resetn; clear (drop all entries); push/push_entry (allocate at tail);
//        fill/fill_inst (complete oldest waiting entry); pop (release head);
//        head_entry, cnt (entries held), pend_cnt (entries waiting for data), fill_hit.
module if_fetch_stage_inst_fifo
  import if_fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   fill,
  input  logic [31:0]            fill_inst,
  input  logic                   pop,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] cnt,
  output logic [$clog2(DEPTH):0] pend_cnt,
  output logic                   fill_hit
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Exception entries are complete on allocation and may sit behind entries
  // still waiting for data, so the fill target is found by scanning from head.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && !mem_q[head_q + PTR_W'(i)].done) begin
        pend_cnt = pend_cnt + CNT_W'(1);
        if (!fill_hit) begin
          fill_hit = 1'b1;
          fill_idx = head_q + PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (fill && fill_hit) begin
        mem_d[fill_idx].inst = fill_inst;
        mem_d[fill_idx].done = 1'b1;
      end
      if (push) begin
        mem_d[tail_q] = push_entry;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign head_entry = mem_q[head_q];
  assign cnt        = cnt_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch address stage
// Purpose: owns the PC, drives the instruction MMU, issues icache requests, tracks
//          in-order outstanding fetches and hands {pc, inst, exc} to decode.
// Ports: clk, resetn; redirect/redirect_pc (squash and refetch);
//        mmu_en/mmu_vaddr -> MMU, mmu_psyaddr_ena/mmu_psyaddr/mmu_uncached/
//        mmu_tlb_refill/mmu_tlb_invalid <- MMU; icache (if_fetch_stage_if.master);
//        out_valid/out_ready/out_pc/out_inst/out_exc -> decode.
// Build option: IF_ADEL_CHECK_EN enables the fetch-address alignment exception.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             mmu_en,
  output logic [31:0]      mmu_vaddr,
  input  logic             mmu_psyaddr_ena,
  input  logic [31:0]      mmu_psyaddr,
  input  logic             mmu_uncached,
  input  logic             mmu_tlb_refill,
  input  logic             mmu_tlb_invalid,
  if_fetch_stage_if.master icache,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [2:0]       out_exc
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic             exc_hold_q, exc_hold_d;
  logic [CNT_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [CNT_W-1:0] fifo_cnt, pend_cnt, occupancy;
  logic             fill_hit;
  fetch_entry_t     head_entry, push_entry;
  logic             room, misaligned, inst_req, accept, tlb_exc, adel_exc;
  logic             push, fill, pop, drop, data_legit;

`ifdef IF_ADEL_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Cancelled requests still occupy icache return slots, so they count
  // against capacity until their data comes back. The sum never exceeds DEPTH.
  assign occupancy = fifo_cnt + cancel_cnt_q;
  assign room      = (occupancy < CNT_W'(DEPTH));

  always_comb begin
    mmu_en     = ~exc_hold_q & room & ~redirect & ~misaligned;
    inst_req   = mmu_en & mmu_psyaddr_ena;
    accept     = inst_req & icache.inst_addr_ok;
    tlb_exc    = mmu_en & ~mmu_psyaddr_ena & (mmu_tlb_refill | mmu_tlb_invalid);
    adel_exc   = ~exc_hold_q & room & ~redirect & misaligned;
    push       = accept | tlb_exc | adel_exc;

    push_entry.pc   = pc_q;
    push_entry.inst = NOP;
    push_entry.exc  = accept ? '0 : make_exc(adel_exc, mmu_tlb_invalid, mmu_tlb_refill);
    push_entry.done = ~accept;

    drop       = icache.inst_data_ok & (cancel_cnt_q != '0);
    fill       = icache.inst_data_ok & (cancel_cnt_q == '0) & ~redirect;
    // A data_ok with nothing outstanding must not disturb the cancel count.
    data_legit = icache.inst_data_ok & ((cancel_cnt_q != '0) | fill_hit);

    out_valid  = (fifo_cnt != '0) & head_entry.done;
    pop        = out_valid & out_ready;
  end

  always_comb begin
    pc_d         = pc_q;
    exc_hold_d   = exc_hold_q;
    cancel_cnt_d = cancel_cnt_q;
    if (redirect) begin
      pc_d         = redirect_pc;
      exc_hold_d   = 1'b0;
      // Everything still waiting for data becomes a return to discard.
      cancel_cnt_d = cancel_cnt_q + pend_cnt + CNT_W'(accept) - CNT_W'(data_legit);
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (tlb_exc | adel_exc) begin
        exc_hold_d = 1'b1;
      end
      if (drop) begin
        cancel_cnt_d = cancel_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q         <= RESET_PC;
      exc_hold_q   <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      exc_hold_q   <= exc_hold_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  if_fetch_stage_inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .fill       (fill),
    .fill_inst  (icache.inst_rdata),
    .pop        (pop),
    .head_entry (head_entry),
    .cnt        (fifo_cnt),
    .pend_cnt   (pend_cnt),
    .fill_hit   (fill_hit)
  );

  assign mmu_vaddr            = pc_q;
  assign icache.inst_req      = inst_req;
  assign icache.inst_uncached = mmu_uncached;
  assign icache.inst_addr     = mmu_psyaddr;
  assign out_pc               = head_entry.pc;
  assign out_inst             = head_entry.inst;
  assign out_exc              = head_entry.exc;

endmodule
